btb_write: RTL and testbench
============================

Name: btb_write

Overview:
- Storage and update side of the 2-way, 8-set branch target buffer.
- Holds the set array and per-set LRU bits, and serves the IF-stage read port: set contents by index, plus the LRU vector.
- Applies EX-stage branch resolutions at the clock edge:
  - 2-bit predictor update on a hit;
  - entry allocation with LRU replacement on a taken miss;
  - LRU refresh on IF-stage hits.

Parameters:
- NUM_SETS, 8, number of sets; fixed with the index width.
- INDEX_W, 3, set index width, taken from PC[4:2].
- TAG_W, 27, tag width, taken from PC[31:5].

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  invalidate all entries at the next edge.
- read_index  input  3  IF-stage set index.
- read_set  output  128  set contents at read_index; combinational from the array.
- LRU  output  8  per-set LRU bits; registered.
- lru_read_we  input  1  IF-stage BTB hit; commit next_LRU_read.
- next_LRU_read  input  1  new LRU bit for read_index.
- update_en  input  1  EX-stage resolved branch valid this cycle.
- update_pc  input  32  PC of the resolved branch.
- update_taken  input  1  actual branch outcome.
- update_target  input  32  resolved target address.
- update_hit  output  1  registered pulse: the previous update hit an entry.
- update_alloc  output  1  registered pulse: the previous update allocated an entry.

Behaviour:
- Set layout (128 bits): way1 = [127:64], way2 = [63:0].
- Way layout (64 bits): valid [63], tag [62:36], target [35:4], state [3:2], reserved [1:0].
  - Reserved bits are always written 0.
- State encoding: STRONG_NOT_TAKEN=00, WEAK_NOT_TAKEN=01, STRONG_TAKEN=10, WEAK_TAKEN=11. Predict-taken = state[1].
- LRU[i] meaning:
  - 0 = way1 most recently used; victim is way2.
  - 1 = way2 most recently used; victim is way1.
- Reset (rst=1 at the edge): all 8 sets = 0, LRU = 8'h00, update_hit = 0, update_alloc = 0. Consequently read_set = 0 for any index. rst overrides every other input.
- flush (rst=0): clears valid in all ways; LRU reset to 0. Tag, target and state bits are left as-is. flush overrides update_en and lru_read_we in the same cycle.
- Update decode: idx = update_pc[4:2], tag = update_pc[31:5].
  - hit1 = valid1 && tag match.
  - hit2 = valid2 && tag match.
  - If both hit, way1 has priority.
- Update, hit case (update_en=1):
  - Taken transitions: 00→01, 01→11, 11→10, 10→10.
  - Not-taken transitions: 10→11, 11→01, 01→00, 00→00.
  - If taken, target ← update_target. If not taken, target is unchanged.
  - LRU[idx] ← 0 for a way1 hit, 1 for a way2 hit.
  - update_hit = 1 on the next cycle.
- Update, miss and taken:
  - Victim selection: way1 if invalid; else way2 if invalid; else the way indicated by LRU[idx].
  - Written entry: valid=1, tag, update_target, state = WEAK_TAKEN (11).
  - LRU[idx] points to the written way.
  - update_alloc = 1 on the next cycle.
- Update, miss and not taken: no array or LRU change; both pulses 0.
- IF-side LRU refresh: if lru_read_we=1, LRU[read_index] ← next_LRU_read.
  - Same index as an active update: the update's LRU value wins.
  - Different index: both writes are applied.
- Latency:
  - Writes become visible on read_set/LRU the cycle after the edge.
  - There is no write-to-read bypass; a same-cycle read returns old data.
- Pulses are single-cycle and are cleared whenever update_en was 0 in the previous cycle.

Test Plan:
- Reset with rst=1 for 2 cycles → read_set=0 for indices 0..7; LRU=8'h00; update_hit=0; update_alloc=0.
- Taken miss, PC=0x0000_1004, target=0x0000_2000 → next cycle: update_alloc=1. Set 1 way1 = {1, 27'h80, 32'h2000, 2'b11, 2'b00}; LRU[1]=0.
- Same PC not taken twice, then taken three times → state sequence 11→01→00→01→11→10; update_hit=1 each following cycle.
- Fill set 1 with PCs 0x1004 and 0x2004 (both taken; LRU[1]=1), then taken PC 0x3004 → way1 replaced; LRU[1]=0.
- lru_read_we=1, read_index=1, next_LRU_read=1, simultaneous with a hit update on way1 of set 1 → LRU[1]=0 (update wins). Repeat with read_index=2 → LRU[2]=1 and LRU[1]=0.
- flush with valid entries present and update_en=1 in the same cycle → all valid bits 0; LRU=0; no allocation; update_alloc=0.

Source files
------------

// File: rtl/btb_write_if.sv
// btb_write_if: IF-stage read port and EX-stage update port of the BTB storage
interface btb_write_if;
  logic         flush;
  logic [2:0]   read_index;
  logic [127:0] read_set;
  logic [7:0]   LRU;
  logic         lru_read_we;
  logic         next_LRU_read;
  logic         update_en;
  logic [31:0]  update_pc;
  logic         update_taken;
  logic [31:0]  update_target;
  logic         update_hit;
  logic         update_alloc;
  modport master (
    output flush, read_index, lru_read_we, next_LRU_read,
           update_en, update_pc, update_taken, update_target,
    input  read_set, LRU, update_hit, update_alloc
  );
  modport slave (
    input  flush, read_index, lru_read_we, next_LRU_read,
           update_en, update_pc, update_taken, update_target,
    output read_set, LRU, update_hit, update_alloc
  );
endinterface

// File: rtl/btb_write.sv
// btb_write: 2-way 8-set BTB storage with predictor update and LRU replacement
module btb_write #(
  parameter int NUM_SETS = 8,
  parameter int INDEX_W  = 3,
  parameter int TAG_W    = 27
) (
  input logic       clk,
  input logic       rst,
  btb_write_if.slave bus
);
  logic [127:0]        set_q [NUM_SETS];
  logic [127:0]        set_d [NUM_SETS];
  logic [NUM_SETS-1:0] lru_q, lru_d;
  logic                hit_q, hit_d, alloc_q, alloc_d;
  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    tag;
  logic [63:0]         w1, w2, new_way;
  logic                hit1, hit2, use_w2;
  function automatic logic [1:0] next_state(input logic [1:0] s, input logic t);
    return t ? (s == 2'b00 ? 2'b01 : s == 2'b01 ? 2'b11 : 2'b10)
             : (s == 2'b10 ? 2'b11 : s == 2'b11 ? 2'b01 : 2'b00);
  endfunction
  function automatic logic [63:0] hit_way(input logic [63:0] w, input logic t, input logic [31:0] tgt);
    return {w[63:36], t ? tgt : w[35:4], next_state(w[3:2], t), 2'b00};
  endfunction
  assign idx     = bus.update_pc[4:2];
  assign tag     = bus.update_pc[31:5];
  assign w1      = set_q[idx][127:64];
  assign w2      = set_q[idx][63:0];
  assign hit1    = w1[63] && (w1[62:36] == tag);
  assign hit2    = w2[63] && (w2[62:36] == tag);
  // LRU=0 means way1 was used last, so way2 is the victim once both are valid
  assign use_w2  = w1[63] && (!w2[63] || !lru_q[idx]);
  assign new_way = {1'b1, tag, bus.update_target, 2'b11, 2'b00};
  always_comb begin
    set_d   = set_q;
    lru_d   = lru_q;
    hit_d   = 1'b0;
    alloc_d = 1'b0;
    if (bus.flush) begin
      for (int i = 0; i < NUM_SETS; i++) begin
        set_d[i][127] = 1'b0;
        set_d[i][63]  = 1'b0;
      end
      lru_d = '0;
    end else begin
      if (bus.lru_read_we) lru_d[bus.read_index] = bus.next_LRU_read;
      if (bus.update_en && hit1) begin
        set_d[idx][127:64] = hit_way(w1, bus.update_taken, bus.update_target);
        lru_d[idx]         = 1'b0;
        hit_d              = 1'b1;
      end else if (bus.update_en && hit2) begin
        set_d[idx][63:0] = hit_way(w2, bus.update_taken, bus.update_target);
        lru_d[idx]       = 1'b1;
        hit_d            = 1'b1;
      end else if (bus.update_en && bus.update_taken) begin
        if (use_w2) set_d[idx][63:0] = new_way;
        else set_d[idx][127:64] = new_way;
        lru_d[idx] = use_w2;
        alloc_d    = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      set_q   <= '{default: '0};
      lru_q   <= '0;
      hit_q   <= 1'b0;
      alloc_q <= 1'b0;
    end else begin
      set_q   <= set_d;
      lru_q   <= lru_d;
      hit_q   <= hit_d;
      alloc_q <= alloc_d;
    end
  end
  assign bus.read_set     = set_q[bus.read_index];
  assign bus.LRU          = lru_q;
  assign bus.update_hit   = hit_q;
  assign bus.update_alloc = alloc_q;
endmodule

// File: tb/tb_btb_write.sv
// tb_btb_write: directed vectors against a way/predictor-level model of the BTB storage
module tb_btb_write;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  btb_write_if bus();
  btb_write dut (.clk(clk), .rst(rst), .bus(bus));
  bit          mv   [8][2];
  logic [26:0] mtag [8][2];
  logic [31:0] mtgt [8][2];
  logic [1:0]  mst  [8][2];
  logic [7:0]  mlru;
  logic        mhit, malloc;
  int          nvec = 0, nerr = 0;
  bit          chk_en = 0;
  // predictor as a saturating confidence level: 0=SNT 1=WNT 2=WT 3=ST
  function automatic logic [1:0] adv(input logic [1:0] s, input logic t);
    int lv;
    lv = (s == 2'b00) ? 0 : (s == 2'b01) ? 1 : (s == 2'b11) ? 2 : 3;
    lv = t ? ((lv < 3) ? lv + 1 : 3) : ((lv > 0) ? lv - 1 : 0);
    return (lv == 0) ? 2'b00 : (lv == 1) ? 2'b01 : (lv == 2) ? 2'b11 : 2'b10;
  endfunction
  function automatic logic [127:0] exp_set(input int i);
    return {mv[i][0], mtag[i][0], mtgt[i][0], mst[i][0], 2'b00,
            mv[i][1], mtag[i][1], mtgt[i][1], mst[i][1], 2'b00};
  endfunction
  task automatic model_step();
    logic [7:0]  old_lru;
    logic [26:0] tg;
    int          idx, w, v;
    old_lru = mlru;
    if (rst) begin
      for (int i = 0; i < 8; i++)
        for (int k = 0; k < 2; k++) begin
          mv[i][k] = 0; mtag[i][k] = '0; mtgt[i][k] = '0; mst[i][k] = '0;
        end
      mlru = '0; mhit = 0; malloc = 0;
    end else if (bus.flush) begin
      for (int i = 0; i < 8; i++)
        for (int k = 0; k < 2; k++) mv[i][k] = 0;
      mlru = '0; mhit = 0; malloc = 0;
    end else begin
      mhit = 0; malloc = 0;
      if (bus.lru_read_we) mlru[bus.read_index] = bus.next_LRU_read;
      if (bus.update_en) begin
        idx = int'(bus.update_pc[4:2]);
        tg  = bus.update_pc[31:5];
        w   = -1;
        for (int k = 1; k >= 0; k--) if (mv[idx][k] && mtag[idx][k] == tg) w = k;
        if (w >= 0) begin
          mst[idx][w] = adv(mst[idx][w], bus.update_taken);
          if (bus.update_taken) mtgt[idx][w] = bus.update_target;
          mlru[idx] = (w == 1);
          mhit = 1;
        end else if (bus.update_taken) begin
          v = !mv[idx][0] ? 0 : !mv[idx][1] ? 1 : (old_lru[idx] ? 0 : 1);
          mv[idx][v] = 1; mtag[idx][v] = tg; mtgt[idx][v] = bus.update_target; mst[idx][v] = 2'b11;
          mlru[idx] = (v == 1);
          malloc = 1;
        end
      end
    end
  endtask
  task automatic cmp(input string nm, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    cmp("model_read_set", bus.read_set, exp_set(int'(bus.read_index)));
    cmp("model_LRU", {120'd0, bus.LRU}, {120'd0, mlru});
    cmp("model_update_hit", {127'd0, bus.update_hit}, {127'd0, mhit});
    cmp("model_update_alloc", {127'd0, bus.update_alloc}, {127'd0, malloc});
  end
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask
  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    bus.update_en = 1; bus.update_pc = pc; bus.update_taken = t; bus.update_target = tgt;
    cyc();
    bus.update_en = 0;
  endtask
  logic [1:0] seq_st [5] = '{2'b01, 2'b00, 2'b01, 2'b11, 2'b10};
  logic       seq_t  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  initial begin
    rst = 1;
    bus.flush = 0; bus.read_index = 0; bus.lru_read_we = 0; bus.next_LRU_read = 0;
    bus.update_en = 0; bus.update_pc = 0; bus.update_taken = 0; bus.update_target = 0;
    cyc();
    chk_en = 1;
    cyc();
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      bus.read_index = 3'(i); #1;
      cmp("reset_read_set", bus.read_set, 128'd0);
    end
    cmp("reset_LRU", {120'd0, bus.LRU}, 128'd0);
    cmp("reset_hit", {127'd0, bus.update_hit}, 128'd0);
    cmp("reset_alloc", {127'd0, bus.update_alloc}, 128'd0);
    bus.read_index = 1;
    upd(32'h0000_1004, 1, 32'h0000_2000);
    cmp("alloc_pulse", {127'd0, bus.update_alloc}, 128'd1);
    cmp("alloc_way1", {64'd0, bus.read_set[127:64]}, {64'd0, 1'b1, 27'h80, 32'h2000, 4'b1100});
    cmp("alloc_lru1", {127'd0, bus.LRU[1]}, 128'd0);
    for (int k = 0; k < 5; k++) begin
      upd(32'h0000_1004, seq_t[k], 32'h0000_5000 + 32'(k));
      cmp("seq_state", {126'd0, bus.read_set[67:66]}, {126'd0, seq_st[k]});
      cmp("seq_hit", {127'd0, bus.update_hit}, 128'd1);
    end
    upd(32'h0000_2004, 1, 32'h0000_2100);
    cmp("fill_way2", {100'd0, bus.read_set[63:36]}, {100'd0, 1'b1, 27'h100});
    cmp("fill_lru1", {127'd0, bus.LRU[1]}, 128'd1);
    upd(32'h0000_3004, 1, 32'h0000_3100);
    cmp("repl_way1", {100'd0, bus.read_set[127:100]}, {100'd0, 1'b1, 27'h180});
    cmp("repl_keep_way2", {100'd0, bus.read_set[63:36]}, {100'd0, 1'b1, 27'h100});
    cmp("repl_lru1", {127'd0, bus.LRU[1]}, 128'd0);
    upd(32'h0000_4004, 0, 32'h0000_4100);
    cmp("nt_miss_hit", {127'd0, bus.update_hit}, 128'd0);
    cmp("nt_miss_alloc", {127'd0, bus.update_alloc}, 128'd0);
    upd(32'h0000_0008, 1, 32'h0000_0100);
    upd(32'h0000_0028, 1, 32'h0000_0200);
    upd(32'h0000_0048, 1, 32'h0000_0300);
    cyc();
    cmp("pulse_clear", {127'd0, bus.update_alloc}, 128'd0);
    bus.lru_read_we = 1; bus.read_index = 1; bus.next_LRU_read = 1;
    upd(32'h0000_3004, 1, 32'h0000_3200);
    cmp("lru_same_idx", {127'd0, bus.LRU[1]}, 128'd0);
    bus.read_index = 2;
    upd(32'h0000_3004, 1, 32'h0000_3300);
    cmp("lru_diff_idx2", {127'd0, bus.LRU[2]}, 128'd1);
    cmp("lru_diff_idx1", {127'd0, bus.LRU[1]}, 128'd0);
    bus.lru_read_we = 0;
    for (int i = 0; i < 8; i++) begin
      bus.read_index = 3'(i);
      cyc();
    end
    bus.flush = 1;
    upd(32'h0000_5004, 1, 32'h0000_5100);
    bus.flush = 0;
    cmp("flush_alloc", {127'd0, bus.update_alloc}, 128'd0);
    cmp("flush_LRU", {120'd0, bus.LRU}, 128'd0);
    for (int i = 0; i < 8; i++) begin
      bus.read_index = 3'(i); #1;
      cmp("flush_valid", {126'd0, bus.read_set[127], bus.read_set[63]}, 128'd0);
    end
    bus.read_index = 1;
    upd(32'h0000_1004, 1, 32'h0000_6000);
    cmp("post_flush_alloc", {127'd0, bus.update_alloc}, 128'd1);
    rst = 1;
    cyc();
    rst = 0;
    cmp("rerst_read_set", bus.read_set, 128'd0);
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
